// File: rtl/fft_pkg.sv
// Shared FFT types and sizing helpers for the streaming FFT stages.
package fft_pkg;

    // Each butterfly stage grows the sample width by one bit so sums and differences never overflow.
    localparam int STAGE_GROWTH = 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Complex feedback delay line for an SDF stage; advances one position only when shift_i is high.
module sdf_delay_line #(
    parameter int DEPTH = 32,
    parameter int DW    = 15
) (
    input  logic          clock,
    input  logic          shift_i,
    input  logic [DW-1:0] din_re_i,
    input  logic [DW-1:0] din_im_i,
    output logic [DW-1:0] dout_re_o,
    output logic [DW-1:0] dout_im_o
);

    logic [DW-1:0] line_re_q [DEPTH];
    logic [DW-1:0] line_im_q [DEPTH];

    // Contents are deliberately not reset: every entry is rewritten before it can reach the output.
    always_ff @(posedge clock) begin
        if (shift_i) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                line_re_q[i] <= line_re_q[i-1];
                line_im_q[i] <= line_im_q[i-1];
            end
            line_re_q[0] <= din_re_i;
            line_im_q[0] <= din_im_i;
        end
    end

    assign dout_re_o = line_re_q[DEPTH-1];
    assign dout_im_o = line_im_q[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF butterfly stage: emits the block's sums, then drains
// the stored differences while holding off input.
module sdf_r2_stage
    import fft_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 14
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     di_en,
    output logic                     di_rdy,
    input  logic signed [WIDTH-1:0]  di_re,
    input  logic signed [WIDTH-1:0]  di_im,
    output logic                     do_en,
    output logic signed [WIDTH:0]    do_re,
    output logic signed [WIDTH:0]    do_im,
    output logic                     do_last
);

    localparam int OW = WIDTH + STAGE_GROWTH;
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   do_en_q, do_en_d;
    logic                   do_last_q, do_last_d;
    logic signed [OW-1:0]   do_re_q, do_re_d;
    logic signed [OW-1:0]   do_im_q, do_im_d;

    logic                   accept;
    logic                   cnt_last;
    logic [CW-1:0]          cnt_inc;
    logic                   shift;
    logic signed [OW-1:0]   x_re, x_im;
    logic signed [OW-1:0]   dl_re, dl_im;
    logic signed [OW-1:0]   din_re, din_im;

    assign di_rdy   = (state_q != DRAIN);
    assign accept   = di_en & di_rdy;
    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_inc  = cnt_last ? '0 : cnt_q + CW'(1);
    assign x_re     = OW'(di_re);
    assign x_im     = OW'(di_im);

    sdf_delay_line #(
        .DEPTH (DEPTH),
        .DW    (OW)
    ) u_delay (
        .clock     (clock),
        .shift_i   (shift),
        .din_re_i  (din_re),
        .din_im_i  (din_im),
        .dout_re_o (dl_re),
        .dout_im_o (dl_im)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift     = 1'b0;
        din_re    = '0;
        din_im    = '0;
        do_en_d   = 1'b0;
        do_last_d = 1'b0;
        do_re_d   = do_re_q;
        do_im_d   = do_im_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    shift  = 1'b1;
                    din_re = x_re;
                    din_im = x_im;
                    cnt_d  = cnt_inc;
                    if (cnt_last) state_d = BFLY;
                end
            end
            BFLY: begin
                if (accept) begin
                    // The entry leaving the line is x[k]; the incoming sample is x[k+DEPTH].
                    shift   = 1'b1;
                    din_re  = dl_re - x_re;
                    din_im  = dl_im - x_im;
                    do_re_d = dl_re + x_re;
                    do_im_d = dl_im + x_im;
                    do_en_d = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                shift     = 1'b1;
                do_re_d   = dl_re;
                do_im_d   = dl_im;
                do_en_d   = 1'b1;
                do_last_d = cnt_last;
                cnt_d     = cnt_inc;
                if (cnt_last) state_d = FILL;
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            do_en_q   <= 1'b0;
            do_last_q <= 1'b0;
            do_re_q   <= '0;
            do_im_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            do_en_q   <= do_en_d;
            do_last_q <= do_last_d;
            do_re_q   <= do_re_d;
            do_im_q   <= do_im_d;
        end
    end

    assign do_en   = do_en_q;
    assign do_last = do_last_q;
    assign do_re   = do_re_q;
    assign do_im   = do_im_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Self-checking bench for sdf_r2_stage: vector tables for the directed cases plus a randomized
// stream checked against a block-level sum/difference model.
module tb_sdf_r2_stage;

    localparam int DEPTH  = 4;
    localparam int WIDTH  = 14;
    localparam int OW     = WIDTH + 1;
    localparam int NROW   = 3 * DEPTH;
    localparam int NBLK   = 6;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   di_en = 1'b0;
    logic                   di_rdy;
    logic signed [WIDTH-1:0] di_re = '0;
    logic signed [WIDTH-1:0] di_im = '0;
    logic                   do_en;
    logic signed [OW-1:0]   do_re;
    logic signed [OW-1:0]   do_im;
    logic                   do_last;

    always #5 clk = ~clk;

    sdf_r2_stage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .di_en   (di_en),
        .di_rdy  (di_rdy),
        .di_re   (di_re),
        .di_im   (di_im),
        .do_en   (do_en),
        .do_re   (do_re),
        .do_im   (do_im),
        .do_last (do_last)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input integer got, input integer exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One row = inputs applied for one cycle, and the outputs expected just after that edge.
    typedef struct {
        bit en;
        int in_re;
        int in_im;
        bit exp_en;
        bit exp_rdy;
        int exp_re;
        int exp_im;
        bit exp_last;
    } row_t;
    typedef row_t tbl_t [NROW];

    function automatic row_t mk(bit en, int ir, int ii, bit ee, bit er, int xr, int xi, bit xl);
        row_t r;
        r = '{en, ir, ii, ee, er, xr, xi, xl};
        return r;
    endfunction

    tbl_t basic, extreme, stall, b2b;

    task automatic run_table(input tbl_t t, input string tag);
        for (int k = 0; k < NROW; k++) begin
            di_en = t[k].en;
            di_re = WIDTH'(t[k].in_re);
            di_im = WIDTH'(t[k].in_im);
            @(posedge clk); #1;
            check($sformatf("%s[%0d].do_en", tag, k), do_en, t[k].exp_en);
            check($sformatf("%s[%0d].di_rdy", tag, k), di_rdy, t[k].exp_rdy);
            if (t[k].exp_en) begin
                check($sformatf("%s[%0d].do_re", tag, k), do_re, t[k].exp_re);
                check($sformatf("%s[%0d].do_im", tag, k), do_im, t[k].exp_im);
                check($sformatf("%s[%0d].do_last", tag, k), do_last, t[k].exp_last);
            end
            $display("[TB] %s row %0d: en=%0b re=%0d -> do_en=%0b do_re=%0d do_im=%0d last=%0b rdy=%0b",
                     tag, k, t[k].en, t[k].in_re, do_en, do_re, do_im, do_last, di_rdy);
        end
        di_en = 1'b0;
    endtask

    // Same block with an idle cycle after every accepted sample; drain must still run back to back.
    task automatic run_bubble(input tbl_t t, input string tag);
        for (int k = 0; k < 2 * DEPTH; k++) begin
            di_en = 1'b1;
            di_re = WIDTH'(t[k].in_re);
            di_im = WIDTH'(t[k].in_im);
            @(posedge clk); #1;
            check($sformatf("%s[%0d].do_en", tag, k), do_en, t[k].exp_en);
            if (t[k].exp_en) check($sformatf("%s[%0d].do_re", tag, k), do_re, t[k].exp_re);
            if (k < 2 * DEPTH - 1) begin
                di_en = 1'b0;
                di_re = WIDTH'(-77);
                @(posedge clk); #1;
                check($sformatf("%s[%0d].gap_do_en", tag, k), do_en, 1'b0);
            end
        end
        for (int k = 2 * DEPTH; k < NROW; k++) begin
            di_en = k[0];
            di_re = WIDTH'(99);
            @(posedge clk); #1;
            check($sformatf("%s[%0d].do_en", tag, k), do_en, 1'b1);
            check($sformatf("%s[%0d].do_re", tag, k), do_re, t[k].exp_re);
            check($sformatf("%s[%0d].do_last", tag, k), do_last, t[k].exp_last);
            $display("[TB] %s drain %0d: do_re=%0d last=%0b", tag, k, do_re, do_last);
        end
        di_en = 1'b0;
    endtask

    typedef struct {
        int re;
        int im;
        bit last;
    } out_t;
    out_t got_q[$];
    out_t exp_q[$];

    always @(posedge clk) begin
        #1;
        if (do_en === 1'b1) got_q.push_back('{int'(do_re), int'(do_im), do_last});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bre[$];
        int bim[$];
        int n_acc;
        int drain_left;
        int blocks;
        int cyc;
        int nchk;

        // Basic block 1..8: sums 6,8,10,12 then four differences of -4.
        for (int k = 0; k < DEPTH; k++) basic[k] = mk(1, k + 1, 0, 0, 1, 0, 0, 0);
        basic[4]  = mk(1, 5, 0, 1, 1, 6, 0, 0);
        basic[5]  = mk(1, 6, 0, 1, 1, 8, 0, 0);
        basic[6]  = mk(1, 7, 0, 1, 1, 10, 0, 0);
        basic[7]  = mk(1, 8, 0, 1, 0, 12, 0, 0);
        basic[8]  = mk(0, 0, 0, 1, 0, -4, 0, 0);
        basic[9]  = mk(0, 0, 0, 1, 0, -4, 0, 0);
        basic[10] = mk(0, 0, 0, 1, 0, -4, 0, 0);
        basic[11] = mk(0, 0, 0, 1, 1, -4, 0, 1);

        extreme[0]  = mk(1, -8192, 8191, 0, 1, 0, 0, 0);
        extreme[1]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
        extreme[2]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
        extreme[3]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
        extreme[4]  = mk(1, 8191, -8192, 1, 1, -1, -1, 0);
        extreme[5]  = mk(1, 0, 0, 1, 1, 0, 0, 0);
        extreme[6]  = mk(1, 0, 0, 1, 1, 0, 0, 0);
        extreme[7]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
        extreme[8]  = mk(0, 0, 0, 1, 0, -16383, 16383, 0);
        extreme[9]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
        extreme[10] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        extreme[11] = mk(0, 0, 0, 1, 1, 0, 0, 1);

        stall = basic;
        for (int k = 2 * DEPTH; k < NROW; k++) begin
            stall[k].en    = 1'b1;
            stall[k].in_re = 99;
            stall[k].in_im = 99;
        end

        b2b[0]  = mk(1, 10, 0, 0, 1, 0, 0, 0);
        b2b[1]  = mk(1, 20, 0, 0, 1, 0, 0, 0);
        b2b[2]  = mk(1, 30, 0, 0, 1, 0, 0, 0);
        b2b[3]  = mk(1, 40, 0, 0, 1, 0, 0, 0);
        b2b[4]  = mk(1, 50, 0, 1, 1, 60, 0, 0);
        b2b[5]  = mk(1, 60, 0, 1, 1, 80, 0, 0);
        b2b[6]  = mk(1, 70, 0, 1, 1, 100, 0, 0);
        b2b[7]  = mk(1, 80, 0, 1, 0, 120, 0, 0);
        b2b[8]  = mk(0, 0, 0, 1, 0, -40, 0, 0);
        b2b[9]  = mk(0, 0, 0, 1, 0, -40, 0, 0);
        b2b[10] = mk(0, 0, 0, 1, 0, -40, 0, 0);
        b2b[11] = mk(0, 0, 0, 1, 1, -40, 0, 1);

        // Reset held for three edges.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.do_en", do_en, 1'b0);
        check("reset.di_rdy", di_rdy, 1'b1);
        check("reset.do_re", do_re, 0);
        check("reset.do_im", do_im, 0);
        check("reset.do_last", do_last, 1'b0);
        $display("[TB] reset: do_en=%0b di_rdy=%0b do_re=%0d do_im=%0d", do_en, di_rdy, do_re, do_im);
        reset_n = 1'b1;

        run_table(basic, "basic");
        run_table(extreme, "extreme");
        run_bubble(basic, "bubble");
        run_table(stall, "stall");
        run_table(basic, "after_stall");

        // Reset in the middle of the butterfly phase.
        for (int k = 0; k < DEPTH + 2; k++) begin
            di_en = 1'b1;
            di_re = WIDTH'(basic[k].in_re + 500);
            di_im = WIDTH'(-3);
            @(posedge clk); #1;
        end
        di_en   = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst.do_en", do_en, 1'b0);
        check("midrst.do_re", do_re, 0);
        check("midrst.do_im", do_im, 0);
        check("midrst.di_rdy", di_rdy, 1'b1);
        $display("[TB] mid-block reset: do_en=%0b do_re=%0d di_rdy=%0b", do_en, do_re, di_rdy);
        reset_n = 1'b1;
        run_table(basic, "post_rst");
        run_table(b2b, "b2b");

        // Randomized stream against the block-level model.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        n_acc = 0;
        drain_left = 0;
        blocks = 0;
        cyc = 0;
        while (blocks < NBLK && cyc < 3000) begin
            bit exp_rdy;
            bit en;
            int r;
            int i;
            exp_rdy = (drain_left == 0);
            check($sformatf("rand.di_rdy@%0d", cyc), di_rdy, exp_rdy);
            en = ($urandom_range(0, 3) != 0);
            r  = int'($urandom_range(0, 16383)) - 8192;
            i  = int'($urandom_range(0, 16383)) - 8192;
            di_en = en;
            di_re = WIDTH'(r);
            di_im = WIDTH'(i);
            if (drain_left > 0) begin
                drain_left--;
            end else if (en) begin
                bre.push_back(r);
                bim.push_back(i);
                n_acc++;
                if (n_acc == 2 * DEPTH) begin
                    for (int k = 0; k < DEPTH; k++)
                        exp_q.push_back('{bre[k] + bre[k+DEPTH], bim[k] + bim[k+DEPTH], 1'b0});
                    for (int k = 0; k < DEPTH; k++)
                        exp_q.push_back('{bre[k] - bre[k+DEPTH], bim[k] - bim[k+DEPTH], k == DEPTH - 1});
                    bre.delete();
                    bim.delete();
                    n_acc = 0;
                    drain_left = DEPTH;
                    blocks++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        di_en = 1'b0;
        repeat (DEPTH + 3) @(posedge clk);
        #2;
        check("rand.blocks_done", blocks, NBLK);
        check("rand.out_count", got_q.size(), exp_q.size());
        nchk = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < nchk; k++) begin
            check($sformatf("rand.out[%0d].re", k), got_q[k].re, exp_q[k].re);
            check($sformatf("rand.out[%0d].im", k), got_q[k].im, exp_q[k].im);
            check($sformatf("rand.out[%0d].last", k), got_q[k].last, exp_q[k].last);
        end
        $display("[TB] random: %0d blocks, %0d outputs compared", blocks, nchk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
